// File: rtl/pingpong_bank_ctrl.sv
// Multi-bank ping-pong line buffer: writes fill banks in rotation, reads drain READY banks in the same order.
// Latency: a word is visible on o_rd_vld no earlier than the edge after its bank closes; banks stream back-to-back.
// Backpressure: read side is valid/ready with a holding output register; the write side has none, so words are dropped while the write bank is READY.
//
// Ports:
//   clk, rst_n                          : clock and synchronous active-low reset
//   i_wr_vld/i_wr_data/i_wr_last        : write word stream (i_wr_last closes the current bank)
//   i_flush                             : discard all bank contents and return both pointers to bank 0
//   o_rd_vld/o_rd_data/o_rd_last/i_rd_rdy : read word stream, o_rd_last marks the final word of a bank
//   o_bank_ready                        : one bit per bank, set while that bank is READY
//   o_wr_bank/o_rd_bank                 : current write and read bank indices
//   o_overflow                          : sticky, set once any word has been dropped
//   o_drop_cnt                          : saturating dropped-word count, present only with PINGPONG_BANK_CTRL_DROP_CNT_EN
module pingpong_bank_ctrl #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int NUM_BANKS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_vld,
    input  logic [DATA_W-1:0]            i_wr_data,
    input  logic                         i_wr_last,
    input  logic                         i_flush,
    output logic                         o_rd_vld,
    output logic [DATA_W-1:0]            o_rd_data,
    output logic                         o_rd_last,
    input  logic                         i_rd_rdy,
    output logic [NUM_BANKS-1:0]         o_bank_ready,
    output logic [$clog2(NUM_BANKS)-1:0] o_wr_bank,
    output logic [$clog2(NUM_BANKS)-1:0] o_rd_bank,
    output logic                         o_overflow
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
    ,
    output logic [15:0]                  o_drop_cnt
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int BANK_W = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_READY   = 2'd2
    } bank_state_t;

    bank_state_t       bank_state [NUM_BANKS];
    logic [CNT_W-1:0]  bank_cnt   [NUM_BANKS];
    logic [DATA_W-1:0] mem        [NUM_BANKS][DEPTH];
    logic [CNT_W-1:0]  rd_addr;     // next word of o_rd_bank to load into the output register

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

    logic              wr_accept;
    logic              wr_drop;
    logic              wr_close;
    logic [CNT_W-1:0]  wr_cnt;
    logic              rd_xfer;
    logic              rd_done;
    logic              rd_load;
    logic [BANK_W-1:0] src_bank;
    logic [CNT_W-1:0]  src_addr;
    logic [CNT_W-1:0]  src_cnt;

    always_comb begin
        wr_cnt    = bank_cnt[o_wr_bank];
        // Bank state is the registered value, so a bank freed on this edge still drops this word.
        wr_accept = i_wr_vld && (bank_state[o_wr_bank] != BANK_READY);
        wr_drop   = i_wr_vld && (bank_state[o_wr_bank] == BANK_READY);
        wr_close  = i_wr_last || (wr_cnt == CNT_W'(DEPTH - 1));

        rd_xfer   = o_rd_vld && i_rd_rdy;
        rd_done   = rd_xfer && o_rd_last;
        // When the last word of a bank leaves, refill straight from the next bank so READY banks stream gap-free.
        src_bank  = rd_done ? next_bank(o_rd_bank) : o_rd_bank;
        src_addr  = rd_done ? '0 : rd_addr;
        src_cnt   = bank_cnt[src_bank];
        rd_load   = (!o_rd_vld || i_rd_rdy) && (bank_state[src_bank] == BANK_READY)
                    && (src_addr < src_cnt);
    end

    always_comb begin
        o_bank_ready = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            o_bank_ready[k] = (bank_state[k] == BANK_READY);
        end
    end

    // Storage is never reset; stale words are unreachable because counts restart at zero.
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && wr_accept) begin
            mem[o_wr_bank][wr_cnt[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                bank_state[k] <= BANK_FREE;
                bank_cnt[k]   <= '0;
            end
            o_wr_bank  <= '0;
            o_rd_bank  <= '0;
            rd_addr    <= '0;
            o_rd_vld   <= 1'b0;
            o_rd_data  <= '0;
            o_rd_last  <= 1'b0;
            o_overflow <= 1'b0;
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
            o_drop_cnt <= '0;
`endif
        end else if (i_flush) begin
            // Flush keeps o_overflow so a drop before the flush is not lost.
            for (int k = 0; k < NUM_BANKS; k++) begin
                bank_state[k] <= BANK_FREE;
                bank_cnt[k]   <= '0;
            end
            o_wr_bank <= '0;
            o_rd_bank <= '0;
            rd_addr   <= '0;
            o_rd_vld  <= 1'b0;
            o_rd_last <= 1'b0;
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
            o_drop_cnt <= '0;
`endif
        end else begin
            if (wr_drop) begin
                o_overflow <= 1'b1;
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
                if (o_drop_cnt != 16'hFFFF) begin
                    o_drop_cnt <= o_drop_cnt + 1'b1;
                end
`else
                // Without the drop counter only the sticky flag records drops.
`endif
            end

            // Write and drain never touch the same bank on one edge: writes need a
            // non-READY bank, the drain only frees a READY one.
            if (wr_accept) begin
                bank_cnt[o_wr_bank]   <= wr_cnt + 1'b1;
                bank_state[o_wr_bank] <= wr_close ? BANK_READY : BANK_FILLING;
                if (wr_close) begin
                    o_wr_bank <= next_bank(o_wr_bank);
                end
            end

            if (rd_done) begin
                bank_state[o_rd_bank] <= BANK_FREE;
                bank_cnt[o_rd_bank]   <= '0;
                o_rd_bank             <= next_bank(o_rd_bank);
            end

            if (rd_load) begin
                o_rd_vld  <= 1'b1;
                o_rd_data <= mem[src_bank][src_addr[ADDR_W-1:0]];
                o_rd_last <= (src_addr == src_cnt - 1'b1);
                rd_addr   <= src_addr + 1'b1;
            end else if (rd_xfer) begin
                // Only the final word can leave without a reload, so the bank is finished.
                o_rd_vld  <= 1'b0;
                o_rd_last <= 1'b0;
                rd_addr   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
module tb_pingpong_bank_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int NB     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_wr_vld;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_wr_last;
    logic              i_flush;
    logic              o_rd_vld;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_last;
    logic              i_rd_rdy;
    logic [NB-1:0]     o_bank_ready;
    logic [0:0]        o_wr_bank;
    logic [0:0]        o_rd_bank;
    logic              o_overflow;
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
    logic [15:0]       o_drop_cnt;
`endif

    always #5 clk = ~clk;

    pingpong_bank_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_BANKS(NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_vld    (i_wr_vld),
        .i_wr_data   (i_wr_data),
        .i_wr_last   (i_wr_last),
        .i_flush     (i_flush),
        .o_rd_vld    (o_rd_vld),
        .o_rd_data   (o_rd_data),
        .o_rd_last   (o_rd_last),
        .i_rd_rdy    (i_rd_rdy),
        .o_bank_ready(o_bank_ready),
        .o_wr_bank   (o_wr_bank),
        .o_rd_bank   (o_rd_bank),
        .o_overflow  (o_overflow)
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
        ,
        .o_drop_cnt  (o_drop_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: each bank is a word array with a fill count and a
    // state (0 free, 1 filling, 2 ready); reads consume words in order.
    logic [DATA_W-1:0] m_dat [NB][DEPTH];
    int                m_st  [NB];
    int                m_cnt [NB];
    int                m_wp, m_rp, m_ridx, m_drop;
    bit                m_ovf;

    bit                prev_ready;
    int                prev_rp;
    bit                hold;
    logic [DATA_W-1:0] hold_dat;
    logic              hold_last;
    int                rd_count;
    logic [DATA_W-1:0] last_dat;

    task automatic model_reset(input bit clr_ovf);
        for (int k = 0; k < NB; k++) begin
            m_st[k]  = 0;
            m_cnt[k] = 0;
        end
        m_wp   = 0;
        m_rp   = 0;
        m_ridx = 0;
        m_drop = 0;
        if (clr_ovf) m_ovf = 1'b0;
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model at the rising edge.
    task automatic step(input bit vld, input logic [DATA_W-1:0] d, input bit last,
                        input bit flush, input bit rdy, input bit rstn);
        logic [NB-1:0] exp_rdy;
        bit            xfer;
        i_wr_vld  = vld;
        i_wr_data = d;
        i_wr_last = last;
        i_flush   = flush;
        i_rd_rdy  = rdy;
        rst_n     = rstn;
        @(negedge clk);
        exp_rdy = '0;
        for (int k = 0; k < NB; k++) exp_rdy[k] = (m_st[k] == 2);
        check_eq("bank_ready", o_bank_ready, exp_rdy);
        check_eq("wr_bank", o_wr_bank, m_wp);
        check_eq("rd_bank", o_rd_bank, m_rp);
        check_eq("overflow", o_overflow, m_ovf);
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
        check_eq("drop_cnt", o_drop_cnt, m_drop);
`endif
        if (m_st[m_rp] != 2) check_eq("rd_vld_idle", o_rd_vld, 0);
        else if (prev_ready && prev_rp == m_rp) check_eq("rd_vld_stream", o_rd_vld, 1);
        if (o_rd_vld && m_st[m_rp] == 2) begin
            if (m_ridx < m_cnt[m_rp]) begin
                check_eq("rd_data", o_rd_data, m_dat[m_rp][m_ridx]);
                check_eq("rd_last", o_rd_last, (m_ridx == m_cnt[m_rp] - 1));
            end else begin
                check_eq("rd_overrun", m_ridx, m_cnt[m_rp] - 1);
            end
        end
        if (hold) begin
            check_eq("hold_vld", o_rd_vld, 1);
            check_eq("hold_data", o_rd_data, hold_dat);
            check_eq("hold_last", o_rd_last, hold_last);
        end
        hold      = o_rd_vld && !rdy && !flush && rstn;
        hold_dat  = o_rd_data;
        hold_last = o_rd_last;
        xfer      = o_rd_vld && rdy;
        if (xfer && rstn && !flush) begin
            rd_count++;
            if (o_rd_last) last_dat = o_rd_data;
        end
        prev_ready = (m_st[m_rp] == 2);
        prev_rp    = m_rp;
        @(posedge clk);
        if (!rstn) begin
            model_reset(1'b1);
        end else if (flush) begin
            model_reset(1'b0);
        end else begin
            if (vld) begin
                if (m_st[m_wp] == 2) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_dat[m_wp][m_cnt[m_wp]] = d;
                    m_cnt[m_wp]++;
                    m_st[m_wp] = 1;
                    if (last || m_cnt[m_wp] == DEPTH) begin
                        m_st[m_wp] = 2;
                        m_wp = (m_wp + 1) % NB;
                    end
                end
            end
            if (xfer && m_st[m_rp] == 2 && m_ridx < m_cnt[m_rp]) begin
                m_ridx++;
                if (m_ridx == m_cnt[m_rp]) begin
                    m_st[m_rp]  = 0;
                    m_cnt[m_rp] = 0;
                    m_ridx      = 0;
                    m_rp        = (m_rp + 1) % NB;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, rdy, 1'b1);
    endtask

    int base;

    initial begin
        prev_ready = 1'b0;
        prev_rp    = 0;
        hold       = 1'b0;
        rd_count   = 0;
        last_dat   = '0;
        m_ovf      = 1'b0;
        model_reset(1'b1);

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("rst_rd_data", o_rd_data, 0);
        check_eq("rst_rd_last", o_rd_last, 0);
        check_eq("rst_rd_vld", o_rd_vld, 0);

        // Full bank 0x0001..0x0004, first word on the first edge out of reset
        base = rd_count;
        for (int k = 1; k <= 4; k++) step(1'b1, 16'(k), 1'b0, 1'b0, 1'b1, 1'b1);
        idle(8, 1'b1);
        check_eq("t1_words", rd_count - base, 4);
        check_eq("t1_last_word", last_dat, 16'h0004);
        check_eq("t1_rd_bank", o_rd_bank, 1);

        // Short line closed by i_wr_last
        base = rd_count;
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("t2_wr_bank", o_wr_bank, 0);
        idle(6, 1'b1);
        check_eq("t2_words", rd_count - base, 2);
        check_eq("t2_last_word", last_dat, 16'hBBBB);

        // Three full banks with reads stalled: third bank's words are dropped
        for (int k = 1; k <= 12; k++) step(1'b1, 16'(k), 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t3_overflow", o_overflow, 1);
        check_eq("t3_bank_ready", o_bank_ready, 2'b11);
`ifdef PINGPONG_BANK_CTRL_DROP_CNT_EN
        check_eq("t3_drop_cnt", o_drop_cnt, 4);
`endif
        base = rd_count;
        idle(12, 1'b1);
        check_eq("t3_words", rd_count - base, 8);
        check_eq("t3_last_word", last_dat, 16'h0008);

        // Flush mid-drain with a concurrent write
        for (int k = 0; k < 4; k++) step(1'b1, 16'h1230 + 16'(k), 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("t4_rd_vld", o_rd_vld, 0);
        check_eq("t4_wr_bank", o_wr_bank, 0);
        check_eq("t4_rd_bank", o_rd_bank, 0);
        check_eq("t4_bank_ready", o_bank_ready, 0);
        check_eq("t4_overflow_kept", o_overflow, 1);
        for (int k = 0; k < 4; k++) step(1'b1, 16'h7700 + 16'(k), 1'b0, 1'b0, 1'b1, 1'b1);
        idle(6, 1'b1);
        check_eq("t4_last_word", last_dat, 16'h7703);

        // One-cycle reset in the middle of a line
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t5_overflow", o_overflow, 0);
        check_eq("t5_rd_data", o_rd_data, 0);
        check_eq("t5_wr_bank", o_wr_bank, 0);
        base = rd_count;
        for (int k = 0; k < 4; k++) step(1'b1, 16'hC000 + 16'(k), 1'b0, 1'b0, 1'b1, 1'b1);
        idle(6, 1'b1);
        check_eq("t5_words", rd_count - base, 4);
        check_eq("t5_last_word", last_dat, 16'hC003);
        check_eq("t5_rd_bank", o_rd_bank, 1);

        // Randomized traffic with a 50% ready
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6,
                 16'($urandom_range(0, 65535)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 399) != 0);
        end
        idle(20, 1'b1);
        check_eq("end_rd_vld", o_rd_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pingpong_bank_ctrl.md
PINGPONG_BANK_CTRL -- requirements
Module: pingpong_bank_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: pixel word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: words per bank; legal range 2..1024, power of two.
REQ-003 SHALL have parameter NUM_BANKS, default 2: bank count; legal range 2..8.
REQ-004 SHALL have port clk, input, 1: the only clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port i_wr_vld, input, 1: write word valid; there is no backpressure.
REQ-007 SHALL have port i_wr_data, input, DATA_W: write word.
REQ-008 SHALL have port i_wr_last, input, 1: last word of a line; sampled only when i_wr_vld=1.
REQ-009 SHALL have port i_flush, input, 1: discard all bank contents.
REQ-010 SHALL have port o_rd_vld, output, 1: read word valid.
REQ-011 SHALL have port o_rd_data, output, DATA_W: read word.
REQ-012 SHALL have port o_rd_last, output, 1: final word of the bank being drained.
REQ-013 SHALL have port i_rd_rdy, input, 1: read-side ready.
REQ-014 SHALL have port o_bank_ready, output, NUM_BANKS: bit k=1 while bank k is READY.
REQ-015 SHALL have port o_wr_bank, output, $clog2(NUM_BANKS): index of the current write bank.
REQ-016 SHALL have port o_rd_bank, output, $clog2(NUM_BANKS): index of the current read bank.
REQ-017 SHALL have port o_overflow, output, 1: sticky flag, set when a word is dropped.

Function
REQ-018 Each bank SHALL hold a state FREE, FILLING or READY, plus a word count of $clog2(DEPTH)+1 bits.
REQ-019 Write side: an accepted word (i_wr_vld=1 and write bank FREE or FILLING) SHALL be stored at address = current count; the bank then becomes FILLING and its count increments.
REQ-020 The write bank SHALL close (state READY, count frozen) on the edge that accepts a word with i_wr_last=1 or the DEPTH-th word; o_wr_bank SHALL advance to (o_wr_bank+1) mod NUM_BANKS on that same edge.
REQ-021 A word arriving while the write bank is READY SHALL be dropped, including any i_wr_last it carries; o_overflow SHALL be set on the next edge.
REQ-022 Read side: o_rd_vld/o_rd_data SHALL be driven from an output register that loads the next word of bank o_rd_bank when the bank is READY, unread words remain, and (o_rd_vld=0 or i_rd_rdy=1).
REQ-023 A transfer SHALL occur only when o_rd_vld=1 and i_rd_rdy=1.
REQ-024 o_rd_vld, o_rd_data and o_rd_last SHALL hold stable while o_rd_vld=1 and i_rd_rdy=0.
REQ-025 If a bank closes on edge N, o_bank_ready SHALL show it from N+1, and o_rd_vld SHALL rise no earlier than N+1 when that bank is o_rd_bank.
REQ-026 o_rd_last SHALL be 1 with the word at address count-1.
REQ-027 On the transfer of the last word, the bank SHALL become FREE and o_rd_bank SHALL advance modulo NUM_BANKS on the same edge.
REQ-028 Back-to-back READY banks SHALL stream with no idle cycle while i_rd_rdy=1.
REQ-029 If a bank frees on the same edge that a write targets it, that write SHALL still be dropped; it is accepted from the next cycle onward.
REQ-030 i_flush=1 SHALL take priority over all other events on the same edge: all banks FREE, counts 0, both pointers 0, o_rd_vld=0. o_overflow SHALL be unchanged by flush.

Reset
REQ-031 While rst_n=0 at an edge: all banks FREE, counts 0, o_wr_bank=0, o_rd_bank=0, o_rd_vld=0, o_rd_last=0, o_rd_data=0, o_bank_ready=0, o_overflow=0.
REQ-032 Reset asserted mid-line or mid-drain SHALL abort the operation with no partial output after release.
REQ-033 The first word SHALL be accepted on the first edge with rst_n=1.
REQ-034 Storage array contents SHALL NOT be reset.

Configuration
REQ-035 With macro PINGPONG_BANK_CTRL_DROP_CNT_EN defined, output o_drop_cnt[15:0] SHALL exist: it increments per dropped word, saturates at 16'hFFFF, resets to 0 on reset and on i_flush.
REQ-036 Without PINGPONG_BANK_CTRL_DROP_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 NUM_BANKS=2, DEPTH=4, i_rd_rdy=1: write 0x0001..0x0004 -> bank0 READY, read 0x0001..0x0004 with o_rd_last on 0x0004, o_rd_bank becomes 1.
REQ-038 Write 0xAAAA,0xBBBB with last on 0xBBBB -> 2-word bank; o_rd_last on 0xBBBB; o_wr_bank advances after 2 words.
REQ-039 i_rd_rdy=0; write 3 full banks of DEPTH=4 -> words 9..12 dropped, o_overflow=1, o_drop_cnt=4 (macro defined).
REQ-040 i_rd_rdy toggled randomly at 50% -> output word sequence equals input sequence and held data is stable while stalled.
REQ-041 i_flush asserted mid-drain with a concurrent write -> next cycle o_rd_vld=0, pointers 0, o_bank_ready=0, concurrent word discarded.
REQ-042 rst_n low for one cycle mid-fill -> all outputs at reset values; next written line is read back intact from bank0.
